// File: rtl/display_scanner.sv
// Four-digit multiplexed scan controller feeding the seven-segment decoder.
// Double-buffered display value, per-digit decimal points, optional leading-zero blanking.
module display_scanner #(
    parameter int unsigned DIV = 50000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dpsel,
    input  logic        i_load,
    input  logic        i_blankzero,
    output logic [3:0]  o_binaryout,
    output logic        o_decout,
    output logic [3:0]  o_anode,
    output logic        o_pending,
    output logic        o_frame
);

    localparam logic [15:0] DIV_M1 = 16'(DIV - 32'd1);

    logic [15:0] r_cnt;
    logic [1:0]  r_dig;
    logic [15:0] r_dispval;
    logic [3:0]  r_dispdp;
    logic [15:0] r_shval;
    logic [3:0]  r_shdp;
    logic        r_pending;
    logic        r_frame;

    logic        w_tick;
    logic        w_boundary;
    logic [3:0]  w_nibble;
    logic        w_dp;
    logic        w_blank;
    logic [3:0]  w_sel;

    assign w_tick     = (r_cnt == DIV_M1);
    assign w_boundary = w_tick && (r_dig == 2'd3);

    // Prescaler, digit stepping, frame pulse and shadow-to-display transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= 16'd0;
            r_dig     <= 2'd0;
            r_dispval <= 16'd0;
            r_dispdp  <= 4'd0;
            r_shval   <= 16'd0;
            r_shdp    <= 4'd0;
            r_pending <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_frame <= w_boundary;
            if (w_tick) begin
                r_cnt <= 16'd0;
                r_dig <= r_dig + 2'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
            // A load landing on the boundary goes straight to the display.
            if (w_boundary) begin
                if (i_load) begin
                    r_dispval <= i_value;
                    r_dispdp  <= i_dpsel;
                end else if (r_pending) begin
                    r_dispval <= r_shval;
                    r_dispdp  <= r_shdp;
                end else begin
                    r_dispval <= r_dispval;
                    r_dispdp  <= r_dispdp;
                end
                r_pending <= 1'b0;
            end else if (i_load) begin
                r_shval   <= i_value;
                r_shdp    <= i_dpsel;
                r_pending <= 1'b1;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

    // Current nibble, decimal point and leading-zero blank condition for the active digit.
    always_comb begin
        w_nibble = 4'h0;
        w_dp     = 1'b0;
        w_blank  = 1'b0;
        w_sel    = 4'b1110;
        case (r_dig)
            2'd0: begin
                w_nibble = r_dispval[3:0];
                w_dp     = r_dispdp[0];
                w_blank  = 1'b0;
                w_sel    = 4'b1110;
            end
            2'd1: begin
                w_nibble = r_dispval[7:4];
                w_dp     = r_dispdp[1];
                w_blank  = (r_dispval[15:4] == 12'd0) && (r_dispdp[3:1] == 3'd0);
                w_sel    = 4'b1101;
            end
            2'd2: begin
                w_nibble = r_dispval[11:8];
                w_dp     = r_dispdp[2];
                w_blank  = (r_dispval[15:8] == 8'd0) && (r_dispdp[3:2] == 2'd0);
                w_sel    = 4'b1011;
            end
            2'd3: begin
                w_nibble = r_dispval[15:12];
                w_dp     = r_dispdp[3];
                w_blank  = (r_dispval[15:12] == 4'd0) && (r_dispdp[3] == 1'b0);
                w_sel    = 4'b0111;
            end
            default: begin
                w_nibble = 4'h0;
                w_dp     = 1'b0;
                w_blank  = 1'b0;
                w_sel    = 4'b1111;
            end
        endcase
    end

    // blankzero is deliberately unregistered so it acts in the same cycle.
    always_comb begin
        o_binaryout = w_nibble;
        o_decout    = ~w_dp;
        o_anode     = w_sel;
        if (i_blankzero && w_blank) begin
            o_decout = 1'b1;
            o_anode  = 4'b1111;
        end else begin
            o_decout = ~w_dp;
            o_anode  = w_sel;
        end
    end

    assign o_pending = r_pending;
    assign o_frame   = r_frame;

endmodule

// File: tb/tb_display_scanner.sv
// Directed self-checking bench for display_scanner: DIV=4 instance for scan/load/blank/reset,
// DIV=1 instance for double load and per-cycle stepping.
module tb_display_scanner;

    logic        clk;
    logic        a_reset, a_load, a_blankzero;
    logic [15:0] a_value;
    logic [3:0]  a_dpsel;
    logic [3:0]  a_binaryout, a_anode;
    logic        a_decout, a_pending, a_frame;

    logic        b_reset, b_load, b_blankzero;
    logic [15:0] b_value;
    logic [3:0]  b_dpsel;
    logic [3:0]  b_binaryout, b_anode;
    logic        b_decout, b_pending, b_frame;

    int n_tests = 0;
    int n_fail  = 0;

    display_scanner #(.DIV(4)) dut_a (
        .i_clk(clk), .i_reset(a_reset), .i_value(a_value), .i_dpsel(a_dpsel),
        .i_load(a_load), .i_blankzero(a_blankzero), .o_binaryout(a_binaryout),
        .o_decout(a_decout), .o_anode(a_anode), .o_pending(a_pending), .o_frame(a_frame)
    );

    display_scanner #(.DIV(1)) dut_b (
        .i_clk(clk), .i_reset(b_reset), .i_value(b_value), .i_dpsel(b_dpsel),
        .i_load(b_load), .i_blankzero(b_blankzero), .o_binaryout(b_binaryout),
        .o_decout(b_decout), .o_anode(b_anode), .o_pending(b_pending), .o_frame(b_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until dut_a raises frame, bounded.
    task automatic wait_frame();
        int n;
        n = 0;
        step();
        while (a_frame !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("frame_wait", {15'd0, a_frame}, 16'd1);
    endtask

    // Walk one full DIV=4 frame starting at digit 0, cnt 0.
    task automatic check_frame(input logic [15:0] val, input logic [3:0] blankmask,
                               input logic [3:0] dp);
        logic [3:0] exp_an;
        logic       exp_dec;
        logic [3:0] sel;
        for (int d = 0; d < 4; d++) begin
            sel = 4'b0001 << d;
            exp_an  = blankmask[d] ? 4'b1111 : ~sel;
            exp_dec = blankmask[d] ? 1'b1 : ~dp[d];
            for (int c = 0; c < 4; c++) begin
                check("anode", {12'd0, a_anode}, {12'd0, exp_an});
                check("binaryout", {12'd0, a_binaryout}, {12'd0, val[4*d +: 4]});
                check("decout", {15'd0, a_decout}, {15'd0, exp_dec});
                check("pending_in_frame", {15'd0, a_pending}, 16'd0);
                check("frame_in_frame", {15'd0, a_frame}, (d == 0 && c == 0) ? 16'd1 : 16'd0);
                step();
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a_reset = 1'b1; a_load = 1'b0; a_blankzero = 1'b0; a_value = 16'h0; a_dpsel = 4'h0;
        b_reset = 1'b1; b_load = 1'b0; b_blankzero = 1'b0; b_value = 16'h0; b_dpsel = 4'h0;
        step();
        step();
        a_reset = 1'b0;
        check("rst_anode", {12'd0, a_anode}, 16'h000E);
        check("rst_bin", {12'd0, a_binaryout}, 16'h0000);
        check("rst_dec", {15'd0, a_decout}, 16'd1);
        check("rst_pending", {15'd0, a_pending}, 16'd0);
        check("rst_frame", {15'd0, a_frame}, 16'd0);

        // Basic scan: load at t=0, transfer after boundary at t=15.
        a_load = 1'b1; a_value = 16'h1A3F; a_dpsel = 4'h0;
        step();
        a_load = 1'b0;
        check("basic_pending", {15'd0, a_pending}, 16'd1);
        wait_frame();
        check_frame(16'h1A3F, 4'b0000, 4'b0000);
        check("frame_period", {15'd0, a_frame}, 16'd1);

        // No tearing: show 1111, then load 2222 on digit 1.
        a_load = 1'b1; a_value = 16'h1111;
        step();
        a_load = 1'b0;
        wait_frame();
        for (int i = 0; i < 4; i++) step();
        check("nt_dig1_anode", {12'd0, a_anode}, 16'h000D);
        a_load = 1'b1; a_value = 16'h2222;
        step();
        a_load = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check("nt_old_digit", {12'd0, a_binaryout}, 16'h0001);
            check("nt_pending", {15'd0, a_pending}, 16'd1);
            step();
        end
        check_frame(16'h2222, 4'b0000, 4'b0000);

        // Boundary coincidence: load in the dig=3, cnt=3 cycle.
        for (int i = 0; i < 15; i++) step();
        check("bc_pre_anode", {12'd0, a_anode}, 16'h0007);
        check("bc_pre_pending", {15'd0, a_pending}, 16'd0);
        a_load = 1'b1; a_value = 16'hBEEF;
        step();
        a_load = 1'b0;
        check("bc_digit0", {12'd0, a_binaryout}, 16'h000F);
        check_frame(16'hBEEF, 4'b0000, 4'b0000);

        // Leading-zero blanking.
        a_blankzero = 1'b1;
        a_load = 1'b1; a_value = 16'h0042; a_dpsel = 4'b0000;
        step();
        a_load = 1'b0;
        wait_frame();
        check_frame(16'h0042, 4'b1100, 4'b0000);
        a_load = 1'b1; a_value = 16'h0042; a_dpsel = 4'b0100;
        step();
        a_load = 1'b0;
        wait_frame();
        check_frame(16'h0042, 4'b1000, 4'b0100);

        // Reset mid-frame while pending, with load held: restart at digit 0.
        a_blankzero = 1'b0;
        a_load = 1'b1; a_value = 16'h7777; a_dpsel = 4'hF;
        step();
        a_load = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("mid_pending", {15'd0, a_pending}, 16'd1);
        a_reset = 1'b1; a_load = 1'b1;
        step();
        step();
        a_reset = 1'b0; a_load = 1'b0;
        check("rst2_anode", {12'd0, a_anode}, 16'h000E);
        check("rst2_bin", {12'd0, a_binaryout}, 16'h0000);
        check("rst2_dec", {15'd0, a_decout}, 16'd1);
        check("rst2_pending", {15'd0, a_pending}, 16'd0);
        check("rst2_frame", {15'd0, a_frame}, 16'd0);
        for (int i = 0; i < 3; i++) step();
        check("rst2_hold_dig0", {12'd0, a_anode}, 16'h000E);
        step();
        check("rst2_dig1", {12'd0, a_anode}, 16'h000D);

        // DIV=1: two loads in one frame, digit advances each cycle.
        b_reset = 1'b0;
        b_load = 1'b1; b_value = 16'hAAAA;
        step();
        b_value = 16'h5555;
        step();
        b_load = 1'b0;
        check("d1_anode_t2", {12'd0, b_anode}, 16'h000B);
        check("d1_pending", {15'd0, b_pending}, 16'd1);
        step();
        check("d1_anode_t3", {12'd0, b_anode}, 16'h0007);
        check("d1_old_bin", {12'd0, b_binaryout}, 16'h0000);
        step();
        check("d1_frame", {15'd0, b_frame}, 16'd1);
        check("d1_anode_t4", {12'd0, b_anode}, 16'h000E);
        check("d1_bin_t4", {12'd0, b_binaryout}, 16'h0005);
        check("d1_pending_clr", {15'd0, b_pending}, 16'd0);
        step();
        check("d1_anode_t5", {12'd0, b_anode}, 16'h000D);
        check("d1_bin_t5", {12'd0, b_binaryout}, 16'h0005);
        check("d1_frame_low", {15'd0, b_frame}, 16'd0);
        step();
        step();
        check("d1_bin_t7", {12'd0, b_binaryout}, 16'h0005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed scan controller that sits directly upstream of the team's seven-segment decoder. It holds a 16-bit ALU result and per-digit decimal-point requests, and steps through the four hex digits at a programmable refresh rate. On each step it drives the current nibble and the decimal point into the decoder, together with the active-low common-anode enables for the board. New values are double-buffered so a digit never changes partway through a scan frame, and optional leading-zero blanking is supported.

## Interface

- DIV, default 50000: clock cycles each digit is held; legal range 1..65535.

- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- value  in  16  hex value to display; nibble k is shown on digit k, with digit 0 least significant.
- dpsel  in  4  decimal-point request per digit, active-high; captured with value.
- load  in  1  single-cycle strobe; captures value and dpsel into the shadow buffer.
- blankzero  in  1  level; enables leading-zero blanking.
- binaryout  out  4  nibble for the decoder's binary input.
- decout  out  1  decimal point for the decoder's dp input; active-low (0 means lit).
- anode  out  4  digit enables; active-low, at most one bit low.
- pending  out  1  high while the shadow buffer holds a value not yet displayed.
- frame  out  1  one-cycle pulse on each frame boundary.

## Operation

- Registers:
  - prescaler cnt, counting 0..DIV-1.
  - digit index dig, 2 bits.
  - display registers dispval[15:0] and dispdp[3:0].
  - shadow registers shval and shdp.
  - pending flag.
  - frame flag.
- tick is asserted when cnt==DIV-1. On a tick, cnt returns to 0 and dig increments modulo 4 (0→1→2→3→0). Otherwise cnt increments. With DIV=1, tick is asserted every cycle.
- A frame boundary is a tick while dig==3. The frame register goes to 1 for exactly the next cycle.
- Load and transfer rules:
  - load on a non-boundary cycle: shval←value, shdp←dpsel, pending←1.
  - Frame boundary with pending=1 and no load: dispval←shval, dispdp←shdp, pending←0.
  - Frame boundary with load=1: dispval←value and dispdp←dpsel are written directly, bypassing the shadow; pending←0.
  - A second load while pending is set overwrites the shadow. Only the latest load is shown.
- Outputs are combinational from the registers:
  - binaryout = dispval[4*dig+3 : 4*dig].
  - decout = ~dispdp[dig].
  - anode = all ones except bit dig, which is 0.
- Leading-zero blanking applies when blankzero=1 and dig≥1. Digit dig is blanked if nibbles dig..3 of dispval are all zero and dispdp[3:dig] is zero. A blanked digit drives anode=4'b1111 and decout=1. binaryout is unchanged. Digit 0 is never blanked.
- blankzero is not registered; it takes effect in the same cycle it changes.

## Timing

- Reset, synchronous: cnt=0, dig=0, dispval=0, dispdp=0, shval=0, shdp=0, pending=0, frame=0. Resulting outputs: anode=4'b1110, binaryout=4'h0, decout=1.
- Reset asserted mid-frame or while pending discards the shadow contents and restarts the scan at digit 0 on the next cycle. Reset overrides load.
- Each digit is displayed for exactly DIV cycles, so a full frame is 4×DIV cycles.
- Load-to-display latency runs from load to the next frame boundary, at most 4×DIV cycles. The new value appears on digit 0 in the cycle after the boundary edge.
- The pending flag rises the cycle after load and falls the cycle after the transferring boundary.

## Test plan

- **Reset:** assert reset for 2 cycles at an arbitrary point in the scan. Required: anode=1110, binaryout=0, decout=1, pending=0, frame=0, and dig restarts at 0.
- **Basic scan (DIV=4):** load value=16'h1A3F, dpsel=0, blankzero=0; wait for the boundary. Required: each digit held for 4 cycles in the sequence anode 1110/F, 1101/3, 1011/A, 0111/1. frame pulses once every 16 cycles.
- **No tearing:** with 16'h1111 displayed, load 16'h2222 while dig=1. Required: pending=1, and the remaining digits still show 1. After the boundary, all digits show 2 and pending=0.
- **Boundary coincidence:** assert load with 16'hBEEF in the exact boundary cycle. Required: digit 0 shows F in the next cycle, and pending stays 0 throughout.
- **Blanking:** load value=16'h0042 with blankzero=1.
  - With dpsel=0: digits 3 and 2 drive anode=1111, and digits 1 and 0 show 4 and 2.
  - With dpsel=4'b0100: digit 2 shows 0 with decout=0, and only digit 3 is blanked.
- **Double load / DIV=1:** with DIV=1, perform two loads inside one frame. Required: only the second value is displayed, and the digit advances every cycle.
